spart_uart: RTL and testbench
=============================

// Module: spart_uart
// PURPOSE
//  Memory-mapped serial port (SPART) on the shared 16-bit CPU databus, selected by External_Mem's CS_Spart decode.
//  Serialises CPU-written bytes onto txd and deserialises rxd into a small RX FIFO, 8N1, 16x oversampled.
//  Gives the processor a debug/host link alongside the PS/2, audio and graphics peripherals; same bus protocol.
// PARAMETERS
//  DIV_RESET   16'd650  baud divisor loaded at reset; tick rate = clk/(DIV+1) = 16x baud
//  RX_DEPTH    4        RX FIFO entries, power of two, >=2
// PORTS
//  clk      in     1   CPU clock (cpuclk)
//  rst      in     1   reset, asynchronous, active-low
//  cs       in     1   chip select (CS_Spart)
//  read     in     1   CPU read strobe
//  write    in     1   CPU write strobe
//  addr     in     2   register select (Addr[1:0])
//  databus  inout  16  shared bus; driven only during cs&read, else 16'hzzzz
//  txd      out    1   serial out, idle high
//  rxd      in     1   serial in, asynchronous, idle high
//  irq      out    1   level: RX FIFO non-empty
// BEHAVIOUR
//  Register map: 00 data (R: pop RX byte in [7:0], [15:8]=0; W: load TX byte [7:0]); 01 status (R only);
//   10 divisor[7:0] (W only); 11 divisor[15:8] (W only). Reads of 10/11 return 0. Writes to 01 ignored.
//  Status: [0] rx_valid, [1] tx_ready, [2] rx_overrun (sticky), [3] framing_err (sticky), [15:4]=0.
//  Bus: read data combinational, valid same cycle cs&read. Each access asserts read/write for exactly 1 cycle.
//   Data read pops FIFO at that clock edge; status read clears bits [3:2] at that edge (value returned pre-clear).
//   Data read with FIFO empty returns 16'h0000, no pointer change. cs&read&write together: treat as read.
//  Reset (async assert, sync release): txd=1, irq=0, divisor=DIV_RESET, FIFO empty, sticky bits 0, status=16'h0002.
//  Baud gen: 16-bit down counter reloads with divisor, 1-cycle tick at 0. Divisor write reloads counter next cycle;
//   frames in flight continue at new rate. Divisor 0 => tick every cycle (legal).
//  TX FSM: TX_IDLE -> TX_START -> TX_DATA(8 bits, LSB first) -> TX_STOP -> TX_IDLE; each bit = 16 ticks.
//   Data write while TX_IDLE: byte latched, tx_ready=0 next cycle, start bit begins on next tick.
//   Write while busy (tx_ready=0): dropped silently. tx_ready=1 in cycle after stop bit's 16th tick.
//  RX: rxd through 2-flop synchroniser. RX FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
//   RX_IDLE: falling edge starts tick count; at 8th tick re-sample; if high -> RX_IDLE (glitch, no byte).
//   Data bits sampled at mid-bit (every 16 ticks); stop sampled mid-bit.
//   Stop=1: push byte; if FIFO full, byte dropped, rx_overrun set. Stop=0: byte discarded, framing_err set,
//   FSM waits for rxd high before re-arming. Push and pop same cycle with FIFO full: both occur, no overrun.
//  FIFO: RX_DEPTH entries, log2(RX_DEPTH)+1-bit pointers, wrap naturally; full = MSB differ, rest equal.
//  Reset mid-frame: both FSMs to idle immediately, partial byte lost, txd high asynchronously.
// STRUCTURE
//  Shared `include spart_defs.vh: register addresses, status bit indices, TX/RX state encodings.
//  One sub-module spart_rx (synchroniser, RX FSM, FIFO); baud gen, TX FSM, bus decode stay at top.
// TESTING
//  Reset: rst low mid-TX frame -> txd=1 within same cycle, status read = 16'h0002, irq=0.
//  TX: divisor=3, write 16'h00A5 -> txd low 64 clks, bits 1,0,1,0,0,1,0,1 at 64 clks each, stop high; tx_ready 0 then 1.
//  Loopback txd->rxd, divisor=3, send 8'h3C -> irq=1, data read = 16'h003C, then irq=0, status = 16'h0002.
//  Overrun: inject RX_DEPTH+1 frames, no reads -> status bit2=1, first RX_DEPTH bytes read back in order.
//  Framing: frame with stop=0 -> status bit3=1, FIFO unchanged; second status read -> bit3=0.
//  Glitch: rxd low for 5 ticks -> no byte, FSM idle; divisor write mid-frame -> next bit uses new period.

Source files
------------

// File: rtl/spart_uart_pkg.sv
// Shared definitions for the SPART: register map, status bit positions and FSM encodings.
package spart_uart_pkg;

  localparam logic [1:0] AddrData   = 2'b00;
  localparam logic [1:0] AddrStatus = 2'b01;
  localparam logic [1:0] AddrDivLo  = 2'b10;
  localparam logic [1:0] AddrDivHi  = 2'b11;

  localparam int unsigned StRxValid  = 0;
  localparam int unsigned StTxReady  = 1;
  localparam int unsigned StOverrun  = 2;
  localparam int unsigned StFrameErr = 3;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/spart_uart_rx.sv
// SPART receiver: rxd synchroniser, 16x-oversampled 8N1 deframer and RX FIFO.
module spart_uart_rx
  import spart_uart_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       tick,
  input  logic       pop,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun_set,
  output logic       frame_set
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic            sync1_q, sync2_q;
  rx_state_e       state_q;
  logic [3:0]      tick_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            wait_high_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [RX_DEPTH];

  logic empty, full, pop_ok, push_req, push;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    push_req = (state_q == RxStop) && tick && (tick_cnt_q == 4'd15) && sync2_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    push     = push_req && (!full || pop_ok);
    rx_valid = !empty;
    rx_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= RxIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_set <= 1'b0;
      frame_set   <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
      overrun_set <= push_req && !push;
      frame_set   <= 1'b0;
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case (state_q)
        RxIdle: begin
          if (wait_high_q) begin
            if (sync2_q) wait_high_q <= 1'b0;
          end else if (!sync2_q) begin
            state_q    <= RxStart;
            tick_cnt_q <= '0;
          end
        end
        RxStart: if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= sync2_q ? RxIdle : RxData;
          end else begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
          end
        end
        RxData: if (tick) begin
          tick_cnt_q <= tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) state_q <= RxStop;
            else bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        RxStop: if (tick) begin
          tick_cnt_q <= tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            state_q <= RxIdle;
            if (!sync2_q) begin
              frame_set   <= 1'b1;
              wait_high_q <= 1'b1;
            end
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/spart_uart.sv
// SPART top: bus register decode, baud generator and 8N1 transmitter; receiver in spart_uart_rx.
module spart_uart
  import spart_uart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd650,
  parameter int unsigned RX_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       read,
  input  logic       write,
  input  logic [1:0] addr,
  inout  wire [15:0] databus,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);

  logic [15:0] div_q, cnt_q;
  logic        reload_q, tick;
  tx_state_e   tx_state_q;
  logic        tx_pend_q;
  logic [3:0]  tx_tick_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        overrun_q, frame_q;
  logic        bus_rd, bus_wr, status_rd, tx_ready;
  logic [15:0] rdata;
  logic [7:0]  rx_data;
  logic        rx_valid, overrun_set, frame_set;

  always_comb begin
    bus_rd    = cs && read;
    bus_wr    = cs && write && !read;
    status_rd = bus_rd && (addr == AddrStatus);
    tx_ready  = (tx_state_q == TxIdle);
    tick      = (cnt_q == 16'd0);
    irq       = rx_valid;
    rdata     = 16'h0000;
    if (addr == AddrData && rx_valid) rdata = {8'h00, rx_data};
    if (addr == AddrStatus) begin
      rdata[StRxValid]  = rx_valid;
      rdata[StTxReady]  = tx_ready;
      rdata[StOverrun]  = overrun_q;
      rdata[StFrameErr] = frame_q;
    end
  end

  assign databus = bus_rd ? rdata : 16'hzzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= DIV_RESET;
      cnt_q     <= DIV_RESET;
      reload_q  <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      reload_q <= 1'b0;
      if (bus_wr && addr == AddrDivLo) begin
        div_q[7:0] <= databus[7:0];
        reload_q   <= 1'b1;
      end
      if (bus_wr && addr == AddrDivHi) begin
        div_q[15:8] <= databus[7:0];
        reload_q    <= 1'b1;
      end
      if (reload_q || tick) cnt_q <= div_q;
      else cnt_q <= cnt_q - 16'd1;
      // A new error arriving in the clearing cycle must not be lost.
      overrun_q <= overrun_set || (overrun_q && !status_rd);
      frame_q   <= frame_set || (frame_q && !status_rd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_pend_q  <= 1'b0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd        <= 1'b1;
    end else begin
      unique case (tx_state_q)
        TxIdle: if (bus_wr && addr == AddrData) begin
          tx_shift_q <= databus[7:0];
          tx_pend_q  <= 1'b1;
          tx_state_q <= TxStart;
        end
        TxStart: if (tick) begin
          if (tx_pend_q) begin
            tx_pend_q <= 1'b0;
            tx_tick_q <= '0;
            txd       <= 1'b0;
          end else begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_bit_q   <= '0;
              txd        <= tx_shift_q[0];
              tx_state_q <= TxData;
            end
          end
        end
        TxData: if (tick) begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            if (tx_bit_q == 3'd7) begin
              txd        <= 1'b1;
              tx_state_q <= TxStop;
            end else begin
              txd        <= tx_shift_q[1];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end
        end
        TxStop: if (tick) begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) tx_state_q <= TxIdle;
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  spart_uart_rx #(
    .RX_DEPTH(RX_DEPTH)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .tick       (tick),
    .pop        (bus_rd && (addr == AddrData)),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .overrun_set(overrun_set),
    .frame_set  (frame_set)
  );

endmodule

// File: tb/tb_spart_uart.sv
// Directed bench for spart_uart: register table, TX waveform, loopback, overrun, framing, glitch,
// mid-frame divisor change and mid-frame reset.
module tb_spart_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [1:0]  addr = 2'b00;
  wire  [15:0] databus;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_wd = 16'h0000;
  logic        txd, irq;
  logic        loop = 1'b0, rxd_drv = 1'b1;
  wire         rxd = loop ? txd : rxd_drv;

  int checks = 0;
  int failures = 0;

  assign databus = tb_oe ? tb_wd : 16'hzzzz;
  always #5 clk = ~clk;

  spart_uart dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .read   (read),
    .write  (write),
    .addr   (addr),
    .databus(databus),
    .txd    (txd),
    .rxd    (rxd),
    .irq    (irq)
  );

  typedef struct {
    logic        is_wr;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; tb_oe = 1'b1; tb_wd = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 d = databus;
    @(posedge clk);
    #1;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic wait_txd(input logic lvl, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (txd === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at a negedge where txd==lvl; returns at the first negedge where it differs.
  task automatic run_len(input logic lvl, output int n);
    n = 1;
    forever begin
      @(negedge clk);
      if (txd !== lvl || n >= 5000) break;
      n++;
    end
  endtask

  // 64 clocks per bit matches divisor 3 (4-clock tick, 16 ticks per bit).
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (64) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (64) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    logic [15:0] s;
    logic        ok;
    logic [7:0]  a5;
    int          n;

    tbl[0] = '{1'b0, 2'b01, 16'h0000, 16'h0002};
    tbl[1] = '{1'b0, 2'b00, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 2'b10, 16'h0000, 16'h0000};
    tbl[3] = '{1'b0, 2'b11, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 2'b01, 16'hFFFF, 16'h0000};
    tbl[5] = '{1'b0, 2'b01, 16'h0000, 16'h0002};
    tbl[6] = '{1'b1, 2'b10, 16'h0003, 16'h0000};
    tbl[7] = '{1'b1, 2'b11, 16'h0000, 16'h0000};
    tbl[8] = '{1'b0, 2'b10, 16'h0000, 16'h0000};
    tbl[9] = '{1'b0, 2'b01, 16'h0000, 16'h0002};

    repeat (3) @(negedge clk);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr) bus_wr(tbl[i].a, tbl[i].d);
      else begin
        bus_rd(tbl[i].a, s);
        check($sformatf("table_%0d", i), {16'd0, s}, {16'd0, tbl[i].exp});
      end
    end

    // TX waveform for 0xA5 at divisor 3
    a5 = 8'hA5;
    bus_wr(2'b00, 16'h00A5);
    bus_rd(2'b01, s);
    check("tx_busy_status", {16'd0, s}, 32'h0000);
    wait_txd(1'b0, ok);
    check("tx_start_seen", {31'd0, ok}, 32'd1);
    run_len(1'b0, n);
    check("tx_start_len", n, 32'd64);
    repeat (32) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tx_bit_%0d", i), {31'd0, txd}, {31'd0, (i == 8) ? 1'b1 : a5[i]});
      repeat (64) @(negedge clk);
    end
    bus_rd(2'b01, s);
    check("tx_done_status", {16'd0, s}, 32'h0002);

    // loopback
    loop = 1'b1;
    bus_wr(2'b00, 16'h003C);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("loop_irq_set", {31'd0, ok}, 32'd1);
    bus_rd(2'b00, s);
    check("loop_data", {16'd0, s}, 32'h003C);
    check("loop_irq_clr", {31'd0, irq}, 32'd0);
    repeat (100) @(negedge clk);
    bus_rd(2'b01, s);
    check("loop_status", {16'd0, s}, 32'h0002);
    loop = 1'b0;

    // overrun: five frames into a four-entry FIFO
    for (int k = 0; k < 5; k++) send_frame(8'(8'h11 * (k + 1)), 1'b1);
    check("ovr_irq", {31'd0, irq}, 32'd1);
    bus_rd(2'b01, s);
    check("ovr_status", {16'd0, s}, 32'h0007);
    for (int k = 0; k < 4; k++) begin
      bus_rd(2'b00, s);
      check($sformatf("ovr_data_%0d", k), {16'd0, s}, {24'd0, 8'(8'h11 * (k + 1))});
    end
    bus_rd(2'b01, s);
    check("ovr_status_clr", {16'd0, s}, 32'h0002);

    // framing error leaves the queued byte alone
    send_frame(8'h77, 1'b1);
    send_frame(8'h5A, 1'b0);
    bus_rd(2'b01, s);
    check("frm_status", {16'd0, s}, 32'h000B);
    bus_rd(2'b01, s);
    check("frm_status_clr", {16'd0, s}, 32'h0003);
    bus_rd(2'b00, s);
    check("frm_data", {16'd0, s}, 32'h0077);
    bus_rd(2'b01, s);
    check("frm_status_end", {16'd0, s}, 32'h0002);

    // 5-tick glitch yields nothing, then a real frame is still received
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (20) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (200) @(negedge clk);
    bus_rd(2'b01, s);
    check("glitch_status", {16'd0, s}, 32'h0002);
    send_frame(8'h96, 1'b1);
    bus_rd(2'b00, s);
    check("glitch_next_data", {16'd0, s}, 32'h0096);

    // divisor changed to 7 during the start bit: later bits are 128 clocks
    bus_wr(2'b00, 16'h000F);
    wait_txd(1'b0, ok);
    check("div_start_seen", {31'd0, ok}, 32'd1);
    bus_wr(2'b10, 16'h0007);
    wait_txd(1'b1, ok);
    check("div_high_seen", {31'd0, ok}, 32'd1);
    run_len(1'b1, n);
    check("div_high_len", n, 32'd512);
    run_len(1'b0, n);
    check("div_low_len", n, 32'd512);
    repeat (200) @(negedge clk);

    // reset in the middle of a start bit
    bus_wr(2'b00, 16'h0055);
    wait_txd(1'b0, ok);
    check("rst_start_seen", {31'd0, ok}, 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_txd_async", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_rd(2'b01, s);
    check("rst_status", {16'd0, s}, 32'h0002);
    repeat (100) @(negedge clk);
    check("rst_txd_idle", {31'd0, txd}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
